// File: rtl/trigger_match_pkg.sv
// Shared constants, mcontrol field positions and slot configuration type for
// the hardware trigger match logic.
package trigger_match_pkg;

  localparam int NUM_TRIG   = 2;
  localparam int DATA_WIDTH = 32;
  localparam int IDX_W      = 1;

  localparam int TYPE_HI   = 31;
  localparam int TYPE_LO   = 28;
  localparam int DMODE     = 27;
  localparam int HIT       = 20;
  localparam int ACTION_HI = 15;
  localparam int ACTION_LO = 12;
  localparam int MATCH_HI  = 10;
  localparam int MATCH_LO  = 7;
  localparam int M         = 6;
  localparam int EXECUTE   = 2;
  localparam int STORE     = 1;
  localparam int LOAD      = 0;

  localparam logic [3:0] MCONTROL_TYPE = 4'd2;
  localparam logic [3:0] MATCH_EQ      = 4'd0;
  localparam logic [3:0] MATCH_GE      = 4'd2;
  localparam logic [3:0] MATCH_LT      = 4'd3;
  localparam logic [3:0] ACTION_BRK    = 4'd0;
  localparam logic [3:0] ACTION_DBG    = 4'd1;

  typedef struct packed {
    logic [3:0]            ttype;
    logic                  dmode;
    logic [3:0]            action;
    logic [3:0]            match;
    logic                  m;
    logic                  execute;
    logic                  store;
    logic                  load;
    logic [DATA_WIDTH-1:0] addr;
  } slot_cfg_t;

  function automatic slot_cfg_t decode_cfg(input logic [DATA_WIDTH-1:0] tdata1,
                                           input logic [DATA_WIDTH-1:0] tdata2);
    slot_cfg_t cfg;
    cfg.ttype   = tdata1[TYPE_HI:TYPE_LO];
    cfg.dmode   = tdata1[DMODE];
    cfg.action  = tdata1[ACTION_HI:ACTION_LO];
    cfg.match   = tdata1[MATCH_HI:MATCH_LO];
    cfg.m       = tdata1[M];
    cfg.execute = tdata1[EXECUTE];
    cfg.store   = tdata1[STORE];
    cfg.load    = tdata1[LOAD];
    cfg.addr    = tdata2;
    return cfg;
  endfunction

  // Unsigned compare of a PC/address against the slot's tdata2.
  function automatic logic addr_cmp(input logic [3:0]            match,
                                    input logic [DATA_WIDTH-1:0] value,
                                    input logic [DATA_WIDTH-1:0] ref_addr);
    logic res;
    case (match)
      MATCH_EQ: res = (value == ref_addr);
      MATCH_GE: res = (value >= ref_addr);
      MATCH_LT: res = (value <  ref_addr);
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/trigger_match_if.sv
// Core-side bundle for the trigger matcher: CSR view, execute/load-store
// observation and the request/acknowledge handshake.
interface trigger_match_if import trigger_match_pkg::*; ();

  logic [IDX_W-1:0]      tselect;
  logic [DATA_WIDTH-1:0] tdata1;
  logic [DATA_WIDTH-1:0] tdata2;
  logic                  cfg_wr;
  logic                  dbg_mode;
  logic                  ex_valid;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic                  ls_valid;
  logic                  ls_store;
  logic [DATA_WIDTH-1:0] ls_addr;
  logic                  trig_ack;
  logic                  trig_req;
  logic                  trig_action;
  logic [IDX_W-1:0]      trig_idx;
  logic [DATA_WIDTH-1:0] trig_tval;
  logic [NUM_TRIG-1:0]   slot_hit;

  modport master (
    output tselect, tdata1, tdata2, cfg_wr, dbg_mode, ex_valid, ex_pc,
           ls_valid, ls_store, ls_addr, trig_ack,
    input  trig_req, trig_action, trig_idx, trig_tval, slot_hit
  );

  modport slave (
    input  tselect, tdata1, tdata2, cfg_wr, dbg_mode, ex_valid, ex_pc,
           ls_valid, ls_store, ls_addr, trig_ack,
    output trig_req, trig_action, trig_idx, trig_tval, slot_hit
  );

endinterface

// File: rtl/trigger_match_cmp.sv
// Per-slot enable decode and execute / load-store address compare.
module trigger_cmp import trigger_match_pkg::*; (
  input  slot_cfg_t             cfg,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ls_valid,
  input  logic                  ls_store,
  input  logic [DATA_WIDTH-1:0] ls_addr,
  output logic                  ex_hit,
  output logic                  ls_hit,
  output logic                  dbg_action
);

  logic enable_s;
  logic match_ok_s;
  logic action_ok_s;
  logic ls_kind_s;

  // Unsupported match/action encodings leave the slot permanently silent.
  always_comb begin
    match_ok_s  = (cfg.match == MATCH_EQ) || (cfg.match == MATCH_GE) ||
                  (cfg.match == MATCH_LT);
    action_ok_s = (cfg.action == ACTION_BRK) || (cfg.action == ACTION_DBG);
    enable_s    = (cfg.ttype == MCONTROL_TYPE) && cfg.m && match_ok_s && action_ok_s;
    ls_kind_s   = ls_store ? cfg.store : cfg.load;
  end

  assign ex_hit     = enable_s && ex_valid && cfg.execute &&
                      addr_cmp(cfg.match, ex_pc, cfg.addr);
  assign ls_hit     = enable_s && ls_valid && ls_kind_s &&
                      addr_cmp(cfg.match, ls_addr, cfg.addr);
  assign dbg_action = (cfg.action == ACTION_DBG) && cfg.dmode;

endmodule

// File: rtl/trigger_match.sv
// Trigger slot configuration, priority selection and the request FSM that
// hands breakpoint/debug-entry requests to the core.
module trigger_match import trigger_match_pkg::*; (
  input  logic            cpu_clk,
  input  logic            cpu_rstn,
  trigger_match_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  slot_cfg_t             slot_cfg_r [NUM_TRIG];
  logic [NUM_TRIG-1:0]   ex_hit_s;
  logic [NUM_TRIG-1:0]   ls_hit_s;
  logic [NUM_TRIG-1:0]   dbg_act_s;
  logic [NUM_TRIG-1:0]   slot_any_s;
  logic [NUM_TRIG-1:0]   slot_hit_r;
  logic [NUM_TRIG-1:0]   slot_hit_nxt_s;
  logic [0:0]            state_r;
  logic                  found_s;
  logic                  fire_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic                  win_act_s;
  logic [DATA_WIDTH-1:0] win_val_s;
  logic                  trig_req_r;
  logic                  trig_action_r;
  logic [IDX_W-1:0]      trig_idx_r;
  logic [DATA_WIDTH-1:0] trig_tval_r;

  // Slot configuration capture from the committed CSR write.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < NUM_TRIG; i++) begin
        slot_cfg_r[i] <= '0;
      end
    end else if (bus.cfg_wr) begin
      slot_cfg_r[bus.tselect] <= decode_cfg(bus.tdata1, bus.tdata2);
    end
  end

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_slot
    trigger_cmp u_cmp (
      .cfg        (slot_cfg_r[g]),
      .ex_valid   (bus.ex_valid),
      .ex_pc      (bus.ex_pc),
      .ls_valid   (bus.ls_valid),
      .ls_store   (bus.ls_store),
      .ls_addr    (bus.ls_addr),
      .ex_hit     (ex_hit_s[g]),
      .ls_hit     (ls_hit_s[g]),
      .dbg_action (dbg_act_s[g])
    );
  end

  assign slot_any_s = (ex_hit_s | ls_hit_s) & {NUM_TRIG{~bus.dbg_mode}};
  assign found_s    = |slot_any_s;
  assign fire_s     = (state_r == ST_IDLE) && found_s;

  // Priority pick: descending scan so the lowest hitting slot is written last.
  always_comb begin
    win_idx_s = {IDX_W{1'b0}};
    win_act_s = 1'b0;
    win_val_s = {DATA_WIDTH{1'b0}};
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      win_idx_s = slot_any_s[i] ? IDX_W'(i) : win_idx_s;
      win_act_s = slot_any_s[i] ? dbg_act_s[i] : win_act_s;
      win_val_s = slot_any_s[i] ? (ex_hit_s[i] ? bus.ex_pc : bus.ls_addr) : win_val_s;
    end
  end

  // Hit bits: a CSR write loads the bit, a simultaneous fire on the same slot wins.
  always_comb begin
    slot_hit_nxt_s                = slot_hit_r;
    slot_hit_nxt_s[bus.tselect]   = bus.cfg_wr ? bus.tdata1[HIT] : slot_hit_r[bus.tselect];
    slot_hit_nxt_s[win_idx_s]     = fire_s ? 1'b1 : slot_hit_nxt_s[win_idx_s];
  end

  // Sticky per-slot hit status register.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      slot_hit_r <= {NUM_TRIG{1'b0}};
    end else begin
      slot_hit_r <= slot_hit_nxt_s;
    end
  end

  // Request FSM: outputs freeze in REQ until the core acknowledges.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_r       <= ST_IDLE;
      trig_req_r    <= 1'b0;
      trig_action_r <= 1'b0;
      trig_idx_r    <= {IDX_W{1'b0}};
      trig_tval_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fire_s) begin
            state_r       <= ST_REQ;
            trig_req_r    <= 1'b1;
            trig_action_r <= win_act_s;
            trig_idx_r    <= win_idx_s;
            trig_tval_r   <= win_val_s;
          end
        end
        ST_REQ: begin
          if (bus.trig_ack) begin
            state_r    <= ST_IDLE;
            trig_req_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          trig_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trig_req    = trig_req_r;
  assign bus.trig_action = trig_action_r;
  assign bus.trig_idx    = trig_idx_r;
  assign bus.trig_tval   = trig_tval_r;
  assign bus.slot_hit    = slot_hit_r;

endmodule

// File: tb/tb_trigger_match.sv
// Scoreboard bench for trigger_match: directed scenarios followed by random
// traffic, checked against a rule-level reference model.
module tb_trigger_match;
  import trigger_match_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  trigger_match_if tif ();

  trigger_match dut (
    .cpu_clk  (clk),
    .cpu_rstn (rstn),
    .bus      (tif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [0:0]  idx;
    logic        act;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] m_t1 [2];
  logic [31:0] m_t2 [2];
  logic [1:0]  m_hit;
  bit          m_pending;
  bit          req_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int ty, input int dm, input int act, input int mt,
                                     input int m, input int ex, input int st, input int ld,
                                     input int hit);
    logic [31:0] v;
    v        = 32'h0;
    v[31:28] = 4'(ty);
    v[27]    = 1'(dm);
    v[20]    = 1'(hit);
    v[15:12] = 4'(act);
    v[10:7]  = 4'(mt);
    v[6]     = 1'(m);
    v[2]     = 1'(ex);
    v[1]     = 1'(st);
    v[0]     = 1'(ld);
    return v;
  endfunction

  function automatic bit mdl_enabled(input logic [31:0] t1);
    int mt;
    mt = int'(t1[10:7]);
    return (t1[31:28] == 4'd2) && t1[6] && (mt == 0 || mt == 2 || mt == 3) &&
           (t1[15:12] <= 4'd1);
  endfunction

  function automatic bit mdl_cmp(input logic [31:0] t1, input logic [31:0] t2,
                                 input logic [31:0] v);
    case (int'(t1[10:7]))
      0:       return v == t2;
      2:       return v >= t2;
      3:       return v < t2;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: evaluates the trigger rules on each clock edge.
  always @(posedge clk or negedge rstn) begin
    bit fired;
    int fidx;
    bit exh;
    bit lsh;
    if (!rstn) begin
      m_t1[0] = 32'h0; m_t1[1] = 32'h0; m_t2[0] = 32'h0; m_t2[1] = 32'h0;
      m_hit = 2'b00;
      m_pending = 1'b0;
      exp_q.delete();
    end else begin
      fired = 1'b0;
      fidx  = 0;
      if (m_pending) begin
        if (tif.trig_ack) m_pending = 1'b0;
      end else if (!tif.dbg_mode) begin
        for (int i = 0; i < 2; i++) begin
          if (!fired && mdl_enabled(m_t1[i])) begin
            exh = tif.ex_valid && m_t1[i][2] && mdl_cmp(m_t1[i], m_t2[i], tif.ex_pc);
            lsh = tif.ls_valid && (tif.ls_store ? m_t1[i][1] : m_t1[i][0]) &&
                  mdl_cmp(m_t1[i], m_t2[i], tif.ls_addr);
            if (exh || lsh) begin
              fired = 1'b1;
              fidx  = i;
              exp_q.push_back('{idx: 1'(i),
                                act: (m_t1[i][15:12] == 4'd1) && m_t1[i][27],
                                val: exh ? tif.ex_pc : tif.ls_addr});
            end
          end
        end
        if (fired) m_pending = 1'b1;
      end
      if (tif.cfg_wr) begin
        m_t1[tif.tselect]  = tif.tdata1;
        m_t2[tif.tselect]  = tif.tdata2;
        m_hit[tif.tselect] = tif.tdata1[20];
      end
      if (fired) m_hit[fidx] = 1'b1;
    end
  end

  // Monitor: compares DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (!rstn) begin
      req_seen = 1'b0;
    end else begin
      check("trig_req", 32'(tif.trig_req), 32'(m_pending));
      check("slot_hit", 32'(tif.slot_hit), 32'(m_hit));
      if (tif.trig_req) begin
        if (!req_seen) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_unexpected: got trig_req=1 expected no pending fire at %0t", $time);
          end else begin
            cur = exp_q.pop_front();
          end
          req_seen = 1'b1;
        end
        check("trig_idx", 32'(tif.trig_idx), 32'(cur.idx));
        check("trig_action", 32'(tif.trig_action), 32'(cur.act));
        check("trig_tval", tif.trig_tval, cur.val);
      end else begin
        req_seen = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tif.tselect  = 1'b0;
    tif.tdata1   = 32'h0;
    tif.tdata2   = 32'h0;
    tif.cfg_wr   = 1'b0;
    tif.dbg_mode = 1'b0;
    tif.ex_valid = 1'b0;
    tif.ex_pc    = 32'h0;
    tif.ls_valid = 1'b0;
    tif.ls_store = 1'b0;
    tif.ls_addr  = 32'h0;
    tif.trig_ack = 1'b0;
  endtask

  task automatic cfg(input int slot, input logic [31:0] t1, input logic [31:0] t2);
    tif.tselect = 1'(slot);
    tif.tdata1  = t1;
    tif.tdata2  = t2;
    tif.cfg_wr  = 1'b1;
    step(1);
    tif.cfg_wr  = 1'b0;
  endtask

  task automatic ack();
    tif.trig_ack = 1'b1;
    step(1);
    tif.trig_ack = 1'b0;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    #12;
    check("rst_req", 32'(tif.trig_req), 32'h0);
    check("rst_action", 32'(tif.trig_action), 32'h0);
    check("rst_idx", 32'(tif.trig_idx), 32'h0);
    check("rst_tval", tif.trig_tval, 32'h0);
    check("rst_hit", 32'(tif.slot_hit), 32'h0);
    step(1);
    rstn = 1'b1;
    step(1);

    // Exact PC match on slot 0.
    cfg(0, 32'h2800_0044, 32'h0000_0100);
    tif.ex_valid = 1'b1; tif.ex_pc = 32'h100;
    step(1);
    tif.ex_valid = 1'b0;
    check("pc_req", 32'(tif.trig_req), 32'h1);
    check("pc_idx", 32'(tif.trig_idx), 32'h0);
    check("pc_action", 32'(tif.trig_action), 32'h0);
    check("pc_tval", tif.trig_tval, 32'h100);
    check("pc_hit", 32'(tif.slot_hit), 32'h1);
    step(2);
    ack();
    check("pc_ack_drop", 32'(tif.trig_req), 32'h0);

    // Store >= on slot 1.
    cfg(1, mk(2, 1, 1, 2, 1, 0, 1, 0, 0), 32'h2000);
    tif.ls_valid = 1'b1; tif.ls_store = 1'b0; tif.ls_addr = 32'h3000;
    step(1);
    tif.ls_store = 1'b1; tif.ls_addr = 32'h1FFC;
    step(1);
    check("ge_no_req", 32'(tif.trig_req), 32'h0);
    tif.ls_addr = 32'h2000;
    step(1);
    tif.ls_valid = 1'b0;
    check("ge_req", 32'(tif.trig_req), 32'h1);
    check("ge_action", 32'(tif.trig_action), 32'h1);
    check("ge_idx", 32'(tif.trig_idx), 32'h1);
    check("ge_tval", tif.trig_tval, 32'h2000);
    ack();
    step(1);

    // Priority: both slots hit the same PC; ack withheld while hits continue.
    cfg(0, mk(2, 1, 0, 0, 1, 1, 0, 0, 0), 32'h500);
    cfg(1, mk(2, 1, 1, 0, 1, 1, 0, 0, 0), 32'h500);
    tif.ex_valid = 1'b1; tif.ex_pc = 32'h500;
    step(1);
    for (int k = 0; k < 5; k++) begin
      check("prio_req", 32'(tif.trig_req), 32'h1);
      check("prio_idx", 32'(tif.trig_idx), 32'h0);
      check("prio_tval", tif.trig_tval, 32'h500);
      check("prio_hit", 32'(tif.slot_hit), 32'h1);
      step(1);
    end
    tif.trig_ack = 1'b1;
    step(1);
    tif.trig_ack = 1'b0; tif.ex_valid = 1'b0;
    step(1);
    check("prio_released", 32'(tif.trig_req), 32'h0);

    // Suppression cases.
    tif.dbg_mode = 1'b1; tif.ex_valid = 1'b1; tif.ex_pc = 32'h500;
    step(3);
    check("dbg_suppress", 32'(tif.trig_req), 32'h0);
    tif.dbg_mode = 1'b0; tif.ex_valid = 1'b0;
    cfg(0, mk(2, 0, 1, 0, 1, 1, 0, 0, 0), 32'h600);
    tif.ex_valid = 1'b1; tif.ex_pc = 32'h600;
    step(1);
    tif.ex_valid = 1'b0;
    check("nodmode_req", 32'(tif.trig_req), 32'h1);
    check("nodmode_action", 32'(tif.trig_action), 32'h0);
    ack();
    cfg(1, mk(2, 1, 0, 1, 1, 1, 1, 1, 0), 32'h700);
    tif.ex_valid = 1'b1; tif.ex_pc = 32'h700;
    tif.ls_valid = 1'b1; tif.ls_addr = 32'h700;
    step(3);
    check("match1_silent", 32'(tif.trig_req), 32'h0);
    idle();

    // Hit clear / set through cfg writes, then reset mid-request.
    cfg(0, mk(2, 0, 1, 0, 1, 1, 0, 0, 0), 32'h600);
    check("hit_clear", 32'(tif.slot_hit[0]), 32'h0);
    cfg(1, mk(2, 1, 0, 1, 1, 1, 1, 1, 1), 32'h700);
    check("hit_set", 32'(tif.slot_hit[1]), 32'h1);
    tif.ex_valid = 1'b1; tif.ex_pc = 32'h600;
    step(1);
    check("pre_rst_req", 32'(tif.trig_req), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_req", 32'(tif.trig_req), 32'h0);
    check("async_rst_hit", 32'(tif.slot_hit), 32'h0);
    step(2);
    rstn = 1'b1;
    step(4);
    check("post_rst_req", 32'(tif.trig_req), 32'h0);
    idle();

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      tif.cfg_wr = ($urandom_range(0, 9) == 0);
      if (tif.cfg_wr) begin
        tif.tselect = 1'($urandom_range(0, 1));
        tif.tdata1  = mk(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 2,
                         int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0) ? 1 : 0,
                         int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                         int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        tif.tdata2  = 32'h100 + 32'($urandom_range(0, 3)) * 32'd4;
      end
      tif.ex_valid = 1'($urandom_range(0, 1));
      tif.ex_pc    = 32'hF8 + 32'($urandom_range(0, 7)) * 32'd4;
      tif.ls_valid = 1'($urandom_range(0, 1));
      tif.ls_store = 1'($urandom_range(0, 1));
      tif.ls_addr  = 32'hF8 + 32'($urandom_range(0, 7)) * 32'd4;
      tif.dbg_mode = ($urandom_range(0, 15) == 0);
      tif.trig_ack = ($urandom_range(0, 2) == 0);
      step(1);
    end
    idle();
    tif.trig_ack = 1'b1;
    step(3);
    tif.trig_ack = 1'b0;
    step(1);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trigger_match.md
Name: trigger_match

Overview:
- Consumer of the trigger CSR block. Holds a per-slot copy of the mcontrol/address configuration for each hardware trigger.
- Compares every retiring execute PC and every load/store address against all enabled slots.
- Raises a registered breakpoint/debug-entry request to the core's exception/debug logic.
- Holds that request under a req/ack handshake and keeps per-slot hit status bits.

Parameters:
- NUM_TRIG, 2, number of trigger slots; indexed by the tselect value.
- DATA_WIDTH, 32, address/data width; must equal `DATA_WIDTH.

Ports:
- cpu_clk  input  1  core clock
- cpu_rstn  input  1  asynchronous, active-low reset
- tselect  input  1  currently selected trigger slot
- tdata1  input  DATA_WIDTH  mcontrol value of the selected slot
- tdata2  input  DATA_WIDTH  compare address of the selected slot
- cfg_wr  input  1  pulse one cycle after a tselect/tdata1/tdata2 write commits; tdata1/tdata2 are stable when it is high
- dbg_mode  input  1  core is in debug mode; suppresses all matching
- ex_valid  input  1  instruction in execute is valid and not flushed
- ex_pc  input  DATA_WIDTH  PC of that instruction
- ls_valid  input  1  load/store access valid this cycle
- ls_store  input  1  1 = store, 0 = load
- ls_addr  input  DATA_WIDTH  effective address
- trig_ack  input  1  core has taken the request
- trig_req  output  1  trigger fired, held until acknowledged
- trig_action  output  1  0 = breakpoint exception, 1 = enter debug mode
- trig_idx  output  1  slot that fired
- trig_tval  output  DATA_WIDTH  matched PC or address
- slot_hit  output  NUM_TRIG  sticky hit bit per slot

Behaviour:
- Reset values: trig_req=0, trig_action=0, trig_idx=0, trig_tval=0, slot_hit=0, FSM=IDLE, all slot configs=0 (disabled).
- Config capture: on a cfg_wr edge, slot[tselect] stores the following tdata1 fields:
  - type[31:28]
  - dmode[27]
  - action[15:12]
  - match[10:7]
  - m[6]
  - execute[2]
  - store[1]
  - load[0]
- Config capture also stores tdata2 as the compare address for that slot.
- Same cfg_wr edge: slot_hit[tselect] is loaded from tdata1[20]. A write with hit=0 clears it; a write with hit=1 sets it.
- Slot enable: type==2, m==1, match in {0,2,3}, action in {0,1}. Any other encoding means the slot never matches.
- Compare is unsigned, full DATA_WIDTH:
  - match=0: equal
  - match=2: value >= tdata2
  - match=3: value < tdata2
- Execute hit on slot i: ex_valid & execute & cmp(ex_pc).
- Load/store hit on slot i: ls_valid & (ls_store ? store : load) & cmp(ls_addr).
- No matching while dbg_mode=1.
- Action 1 is honoured only when dmode=1; otherwise the slot is treated as action 0.
- Priority within a cycle: lowest slot index first; within a slot, execute before load/store.
- FSM IDLE, on any hit:
  - next edge: go to REQ, assert trig_req.
  - register trig_idx, trig_action and trig_tval (the PC or address that hit).
  - set slot_hit[idx].
- Latency: hit cycle N gives trig_req=1 in cycle N+1.
- FSM REQ: outputs are held stable. trig_ack=1 at an edge returns to IDLE, and trig_req=0 from the next cycle.
- trig_ack sampled in IDLE is ignored.
- Hits arriving while in REQ, including the ack cycle, are dropped and do not set slot_hit. Matching resumes with the first cycle in IDLE.
- cfg_wr during REQ updates the slot config only; the pending request is not altered.
- cfg_wr and a hit in the same cycle: the compare uses the old config; the new config takes effect next cycle.
- Hit bit: if cfg_wr writes slot_hit[k] in the same cycle that the FSM sets slot_hit[k] for a new fire, the set from the fire wins.
- Asynchronous reset at any point, including mid-REQ, returns all state to reset values immediately.

Decomposition:
- Add to dbg_defines.vh:
  - mcontrol field bit positions: TYPE, DMODE, HIT, ACTION, MATCH, M, EXECUTE, STORE, LOAD.
  - MCONTROL_TYPE=2.
  - MATCH_EQ=0, MATCH_GE=2, MATCH_LT=3.
  - ACTION_BRK=0, ACTION_DBG=1.
- One sub-module, trigger_cmp. It is instantiated once per slot and does the combinational enable decode plus the execute and load/store compare. It outputs ex_hit and ls_hit.
- The top level holds the slot config registers, the priority encoder and the FSM.

Test Plan:
- Exact PC match:
  - Stimulus: slot0 configured with tdata1=0x2800_0044 (type 2, dmode 1, action 0, m 1, execute 1) and tdata2=0x0000_0100; then ex_valid with ex_pc=0x100.
  - Required: next cycle trig_req=1, trig_idx=0, trig_action=0, trig_tval=0x100, slot_hit=2'b01.
  - Then trig_ack=1: trig_req=0 the following cycle.
- Store >= match:
  - Stimulus: slot1 configured with match=2, store=1, action=1, dmode=1, tdata2=0x2000; then a load to 0x3000, then a store to 0x1FFC, then a store to 0x2000.
  - Required: the load and the 0x1FFC store produce no request; the 0x2000 store gives trig_req with trig_action=1, trig_idx=1, trig_tval=0x2000.
- Priority:
  - Stimulus: both slots enabled to hit the same ex_pc in one cycle.
  - Required: trig_idx=0; slot_hit=2'b01.
  - Then, with ack withheld for 5 cycles and hits continuing, trig_req stays held, outputs are stable, and slot_hit stays 2'b01.
- Suppression:
  - dbg_mode=1 with a matching ex_pc gives no trig_req.
  - A slot with action=1 and dmode=0 fires with trig_action=0.
  - A slot with match=1 never fires.
- Hit clear and reset:
  - Stimulus: a cfg_wr to slot0 with tdata1[20]=0 after a fire.
  - Required: slot_hit[0]=0.
  - Assert cpu_rstn low while trig_req=1: trig_req and slot_hit drop asynchronously, and no request appears after release.
